// File: rtl/down_counter.sv
// rtl/down_counter.sv - loadable, enable-gated down-counter / countdown timer with terminal-count pulse and optional auto-reload
module down_counter #(
    parameter int WIDTH     = 8,
    parameter int MAX_VALUE = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [WIDTH-1:0] MAX_V = MAX_VALUE[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE_V = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;
    logic [WIDTH-1:0] lv;
    logic             count_gt1;
    logic             count_is1;

    // Saturate the requested start value to the largest loadable value
    always_comb begin
        lv = (load_value > MAX_V) ? MAX_V : load_value;
    end

    // Decode count magnitude used by the terminal-count decision
    always_comb begin
        count_gt1 = (count_q > ONE_V);
        count_is1 = (count_q == ONE_V);
    end

    // Next-state, next-count and terminal-count decision; load always wins over en
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;

        if (load) begin
            reload_d = lv;
            if (lv != '0) begin
                count_d = lv;
                state_d = ST_HOLD;
            end else begin
                count_d = '0;
                state_d = ST_DONE;
                tc_d    = 1'b1;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    count_d = '0;
                end
                ST_HOLD, ST_RUN: begin
                    if (!en) begin
                        // Pausing from RUN parks in HOLD with the count frozen
                        state_d = ST_HOLD;
                    end else if (count_gt1) begin
                        count_d = count_q - ONE_V;
                        state_d = ST_RUN;
                    end else if (count_is1) begin
                        // Terminal edge: auto_reload is only looked at here
                        tc_d = 1'b1;
                        if (auto_reload) begin
                            count_d = reload_q;
                            state_d = ST_RUN;
                        end else begin
                            count_d = '0;
                            state_d = ST_DONE;
                        end
                    end else begin
                        // A zero count here is unreachable; never decrement from 0
                        count_d = '0;
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    count_d = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    // State, count, reload and tc registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    // Outputs come straight from registers; busy is a pure state decode
    always_comb begin
        count = count_q;
        tc    = tc_q;
        state = state_q;
        busy  = (state_q == ST_HOLD) || (state_q == ST_RUN);
    end

endmodule

// File: tb/tb_down_counter.sv
// tb/tb_down_counter.sv - directed self-checking bench for down_counter
module tb_down_counter;

    logic       clk;
    logic       rst;
    logic       load;
    logic [7:0] load_value;
    logic       en;
    logic       auto_reload;
    logic [7:0] count;
    logic       tc;
    logic       busy;
    logic [1:0] state;

    int n_vec;
    int n_err;

    down_counter #(.WIDTH(8), .MAX_VALUE(9)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_value (load_value),
        .en         (en),
        .auto_reload(auto_reload),
        .count      (count),
        .tc         (tc),
        .busy       (busy),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_all(input string tag, input int c, input int t, input int b, input int s);
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".tc"},    32'(tc),    32'(t));
        chk({tag, ".busy"},  32'(busy),  32'(b));
        chk({tag, ".state"}, 32'(state), 32'(s));
    endtask

    initial begin
        int tc_pulses;
        int exp_c;
        n_vec = 0;
        n_err = 0;
        rst = 1'b0;
        load = 1'b0;
        load_value = 8'd0;
        en = 1'b0;
        auto_reload = 1'b0;

        // 1. reset and IDLE
        #2;
        chk_all("reset", 0, 0, 0, 0);
        #18;
        rst = 1'b1;
        @(negedge clk);
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_all("idle_en", 0, 0, 0, 0);
        end

        // 2. load 5, hold, run to DONE
        en = 1'b0; load = 1'b1; load_value = 8'd5;
        tick();
        load = 1'b0;
        chk_all("load5", 5, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("hold5", 5, 0, 1, 1);
        end
        en = 1'b1;
        tick(); chk_all("run4", 4, 0, 1, 2);
        tick(); chk_all("run3", 3, 0, 1, 2);
        tick(); chk_all("run2", 2, 0, 1, 2);
        tick(); chk_all("run1", 1, 0, 1, 2);
        tick(); chk_all("done0", 0, 1, 0, 3);
        tick(); chk_all("done_tc_clr", 0, 0, 0, 3);
        tick(); chk_all("done_stay", 0, 0, 0, 3);

        // 3. pause mid-run
        en = 1'b0; load = 1'b1; load_value = 8'd7;
        tick(); load = 1'b0;
        chk_all("load7", 7, 0, 1, 1);
        en = 1'b1;
        tick(); tick();
        chk_all("run5", 5, 0, 1, 2);
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_all("pause5", 5, 0, 1, 1);
        end
        en = 1'b1;
        tick(); chk_all("resume4", 4, 0, 1, 2);

        // 4. saturation and auto-reload period of 9
        en = 1'b0; load = 1'b1; load_value = 8'd10;
        tick(); chk_all("sat10", 9, 0, 1, 1);
        load_value = 8'd200;
        tick(); load = 1'b0;
        chk_all("sat200", 9, 0, 1, 1);
        auto_reload = 1'b1; en = 1'b1;
        tc_pulses = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            exp_c = (k % 9 == 0) ? 9 : 9 - (k % 9);
            chk_all($sformatf("ar_k%0d", k), exp_c, (k % 9 == 0) ? 1 : 0, 1, 2);
            if (tc) tc_pulses++;
        end
        chk("ar_pulses", 32'(tc_pulses), 32'd3);

        // 5. load beats en while RUN at 6; zero load
        load = 1'b1; load_value = 8'd3; en = 1'b1;
        tick(); chk_all("prio3", 3, 0, 1, 1);
        load_value = 8'd0;
        tick(); load = 1'b0;
        chk_all("zero_load", 0, 1, 0, 3);
        tick(); chk_all("zero_tc_clr", 0, 0, 0, 3);

        // reload_reg = 1 with auto_reload: tc every enabled cycle
        en = 1'b0; load = 1'b1; load_value = 8'd1;
        tick(); load = 1'b0;
        chk_all("load1", 1, 0, 1, 1);
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("per1", 1, 1, 1, 2);
        end

        // 6. asynchronous reset mid-run
        auto_reload = 1'b0; en = 1'b0; load = 1'b1; load_value = 8'd9;
        tick(); load = 1'b0;
        chk_all("load9", 9, 0, 1, 1);
        en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk_all("pre_rst4", 4, 0, 1, 2);
        #1 rst = 1'b0;
        #1 chk_all("async_rst", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("post_rst", 0, 0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/down_counter.md
Name: down_counter

Overview:
Loadable, enable-gated down-counter and countdown timer. It is the decrementing counterpart of the `counter` up-counter: it loads a start value, counts down to zero under `en`, and flags terminal count on `tc`. It has the same RESET/HOLD/RUN state vocabulary as `counter`, plus a DONE state. An optional auto-reload mode makes it a periodic tick source.

Parameters:
- WIDTH, 8, bit width of `count` and `load_value`.
- MAX_VALUE, 9, largest loadable value; larger loads saturate to it. Must satisfy 1 <= MAX_VALUE <= 2^WIDTH-1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (0 = reset)
- load  input  1  load request; sampled at rising edge
- load_value  input  WIDTH  start value, captured when `load`=1
- en  input  1  count enable
- auto_reload  input  1  1 = reload and continue at terminal count; 0 = stop in DONE
- count  output  WIDTH  current count (registered)
- tc  output  1  terminal-count pulse (registered, one cycle)
- busy  output  1  1 when state is HOLD or RUN
- state  output  2  current state: IDLE=0, HOLD=1, RUN=2, DONE=3

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately and mid-operation):
  - count=0, tc=0, busy=0, state=IDLE, internal reload_reg=0.
  - On rst rising, the first active edge is the next rising clk edge.
- All outputs are registered. busy is decoded from the state register only.
- Load value: lv = (load_value > MAX_VALUE) ? MAX_VALUE : load_value. Compare unsigned, at full WIDTH.
- load=1 at an edge, in any state:
  - Sets reload_reg=lv and tc=0.
  - If lv != 0: count=lv, state=HOLD.
  - If lv == 0: count=0, state=DONE, tc=1 for that one following cycle.
  - load has priority over en; no decrement happens on a load edge.
- IDLE: en is ignored; count stays 0; waits for load.
- HOLD:
  - en=1: count=count-1, state=RUN. The decrement is taken on the same edge as the transition.
  - en=0: no change.
- RUN:
  - en=0: state=HOLD, count unchanged.
  - en=1 and count>1: count=count-1.
  - en=1, count==1, auto_reload=0: count=0, state=DONE, tc=1 for one cycle.
  - en=1, count==1, auto_reload=1: count=reload_reg, state stays RUN, tc=1 for one cycle. Period is exactly reload_reg enabled cycles; count never shows 0.
- DONE: count holds 0; en and auto_reload are ignored; only load or reset leaves DONE.
- tc:
  - High only in the cycle immediately after the terminal edge; cleared on the next edge unless another terminal event occurs.
  - With reload_reg=1 and auto_reload=1, tc stays high every enabled cycle.
- count never underflows. No decrement is performed from 0 in any state.
- auto_reload is sampled only at the terminal edge. Changing it mid-count has no other effect.

Test Plan:
1. Reset and IDLE: rst=0 for 20 ns, then rst=1, en=1 for 5 cycles, no load -> count=0, tc=0, busy=0, state=0 throughout.
2. Load, HOLD and run to DONE:
   - load=1 with load_value=5 for one cycle, en=0 for 3 cycles -> count=5, state=1 (HOLD).
   - Then en=1 -> count 4,3,2,1,0 on consecutive edges; tc=1 exactly in the cycle count=0; state=3.
   - en held further -> count stays 0.
3. Pause mid-run: load 7, en=1 for 2 cycles (count=5), en=0 for 4 cycles -> count holds 5, state=1. Then en=1 -> resumes at 4.
4. Auto-reload and saturation:
   - load_value=200 with MAX_VALUE=9 -> count=9.
   - auto_reload=1, en=1 for 30 cycles -> tc pulses every 9 cycles (3 pulses); count sequence 9..1,9..1; state stays 2.
5. Priority and zero load:
   - load=1 (value 3) and en=1 on the same edge while RUN at count=6 -> count=3, state=1, no decrement.
   - load_value=0 -> count=0, state=3, single tc pulse.
6. Reset mid-run: load 9, en=1, assert rst=0 asynchronously between clock edges at count=4 -> outputs go to reset values immediately, not at the next edge. After release, en=1 without load -> count stays 0.
